// File: rtl/dc_sched_pkg.sv
// dc_sched_pkg: shared widths, sample type and scheduler states for the DC filter scheduler
package dc_sched_pkg;
    localparam int DATA_W = 9;
    typedef logic [DATA_W-1:0] sample_t;
    typedef enum logic {IDLE, RUN} sched_state_t;
endpackage

// File: rtl/dc_filter_core.sv
// dc_filter_core: one step of the leaky DC-blocking recurrence y = x - xp + yp*(1-2^-SHIFT)
module dc_filter_core
    import dc_sched_pkg::*;
#(
    parameter int SHIFT = 18
) (
    input  sample_t x,
    input  sample_t xp,
    input  sample_t yp,
    output sample_t y
);
    logic [DATA_W:0]  hr;
    logic [SHIFT-2:0] unused_lo;

    // leak term: top DATA_W bits of yp*(2^SHIFT-1) plus the rounding bit just below them
    always_comb begin
        {hr, unused_lo} = {yp, {SHIFT{1'b0}}} - (DATA_W + SHIFT)'(yp);
        y = x - xp + hr[DATA_W:1] + DATA_W'(hr[0]);
    end
endmodule

// File: rtl/dc_filter_scheduler.sv
// dc_filter_scheduler: time-multiplexed DC-blocking filter, one channel per CLK_24M cycle
module dc_filter_scheduler
    import dc_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SHIFT  = 18
) (
    input  logic                     reset,
    input  logic                     CLK_24M,
    input  logic                     enable_3M,
    input  logic [NUM_CH*DATA_W-1:0] c_data,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        ch_clear,
    input  logic                     overrun_clr,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic                     o_valid,
    output logic                     busy,
    output logic                     overrun
);
    localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    sched_state_t      state, state_next;
    logic [IDX_W-1:0]  ch_idx;
    logic [NUM_CH-1:0] snap_en, snap_clr;
    sample_t           snap_x [NUM_CH];
    sample_t           x_prev [NUM_CH];
    sample_t           y_prev [NUM_CH];
    sample_t           out_q  [NUM_CH];
    sample_t           xp, yp, y;
    logic              last;

    assign last = ch_idx == LAST;
    assign xp   = snap_clr[ch_idx] ? '0 : x_prev[ch_idx];
    assign yp   = snap_clr[ch_idx] ? '0 : y_prev[ch_idx];

    dc_filter_core #(.SHIFT(SHIFT)) u_core (
        .x  (snap_x[ch_idx]),
        .xp (xp),
        .yp (yp),
        .y  (y)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_out
        assign o_data[k*DATA_W +: DATA_W] = out_q[k];
    end

    // state register
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // next state: accept a strobe when idle, return to idle after the last channel slot
    always_comb begin
        state_next = (state == IDLE) ? (enable_3M ? RUN : IDLE) : (last ? IDLE : RUN);
        busy       = state == RUN;
    end

    // snapshot, per-channel state banks, output slices and flags
    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            ch_idx   <= '0;
            snap_en  <= '0;
            snap_clr <= '0;
            o_valid  <= 1'b0;
            overrun  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_x[k] <= '0;
                x_prev[k] <= '0;
                y_prev[k] <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            o_valid <= 1'b0;
            overrun <= (enable_3M && state == RUN) ? 1'b1 : (overrun_clr ? 1'b0 : overrun);
            if (state == IDLE && enable_3M) begin
                ch_idx   <= '0;
                snap_en  <= ch_en;
                snap_clr <= ch_clear;
                for (int k = 0; k < NUM_CH; k++) snap_x[k] <= c_data[k*DATA_W +: DATA_W];
            end
            if (state == RUN) begin
                ch_idx  <= last ? '0 : ch_idx + 1'b1;
                o_valid <= last;
                if (snap_en[ch_idx]) begin
                    x_prev[ch_idx] <= snap_x[ch_idx];
                    y_prev[ch_idx] <= y;
                    out_q[ch_idx]  <= y;
                end else begin
                    x_prev[ch_idx] <= xp;
                    y_prev[ch_idx] <= yp;
                    out_q[ch_idx]  <= '0;
                end
            end
        end
    end
endmodule
